// File: rtl/bus_requester_pkg.sv
// Shared types and constants for the backplane bus requester and its timeout counter.
// Holds the FSM state encoding and the abort cause codes.
package bus_requester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_ADDRESS = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ABORT   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_GRANT_TO  = 2'b01;
  localparam logic [1:0] ERR_TARGET_TO = 2'b10;
  localparam logic [1:0] ERR_ARB       = 2'b11;

  function automatic logic is_arb_error(input logic [1:0] status);
    return status != ERR_NONE;
  endfunction

endpackage

// File: rtl/bus_requester_if.sv
// Backplane bus signals between one requester slot and the central arbiter.
// Handshake: the requester holds barq_o until bagd_i is seen, then holds
// address_valid_o until target_ready_i; every cycle with data_strobe_i moves one
// word; after barq_o drops the arbiter lowers bagd_i to close the tenure.
interface bus_requester_if;
  logic       barq_o;
  logic       bagd_i;
  logic       address_valid_o;
  logic       target_ready_i;
  logic       data_strobe_i;
  logic [1:0] error_i;

  modport master (
    output barq_o,
    output address_valid_o,
    input  bagd_i,
    input  target_ready_i,
    input  data_strobe_i,
    input  error_i
  );

  modport slave (
    input  barq_o,
    input  address_valid_o,
    output bagd_i,
    output target_ready_i,
    output data_strobe_i,
    output error_i
  );
endinterface

// File: rtl/bus_timeout_cnt.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags expiry
// for exactly one cycle when the count reaches CLK_MAX_TIMEOUT-1.
module bus_timeout_cnt #(
  parameter int CLK_MAX_TIMEOUT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(CLK_MAX_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_MAX_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_enable & ~i_clear & (r_cnt == LAST);

  // Self-clearing on expiry keeps the expired flag to a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_expired) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bus_requester.sv
// Device-side bus initiator: request/grant, address phase, strobe counting and
// release, with a per-state watchdog and abort on arbiter error or lost grant.
module bus_requester
  import bus_requester_pkg::*;
#(
  parameter int CLK_MAX_TIMEOUT = 10,
  parameter int LEN_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output state_t             state_o,
  output logic [LEN_W-1:0]   cnt_o,
  bus_requester_if.master    bus
);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             r_barq;
  logic             r_av;

  logic             w_arb_abort;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_progress;
  logic             w_tmr_en;
  logic             w_tmr_clear;
  logic             w_expired;

  assign w_arb_abort = is_arb_error(bus.error_i) | ~bus.bagd_i;
  assign w_cnt_inc   = r_cnt + LEN_W'(1);

  // Any non-timeout exit from a waiting state (and every strobe) restarts the watchdog.
  always_comb begin
    w_progress = 1'b1;
    case (r_state)
      ST_REQUEST: w_progress = bus.bagd_i;
      ST_ADDRESS: w_progress = bus.target_ready_i | w_arb_abort;
      ST_DATA:    w_progress = bus.data_strobe_i | w_arb_abort;
      ST_RELEASE: w_progress = ~bus.bagd_i;
      default:    w_progress = 1'b1;
    endcase
  end

  assign w_tmr_en    = (r_state == ST_REQUEST) || (r_state == ST_ADDRESS) ||
                       (r_state == ST_DATA)    || (r_state == ST_RELEASE);
  assign w_tmr_clear = w_progress;

  bus_timeout_cnt #(
    .CLK_MAX_TIMEOUT (CLK_MAX_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_barq     <= 1'b0;
      r_av       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_len      <= len_i;
            r_cnt      <= '0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b1;
            r_barq     <= 1'b1;
            r_state    <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (bus.bagd_i) begin
            r_av    <= 1'b1;
            r_state <= ST_ADDRESS;
          end else if (w_expired) begin
            r_barq     <= 1'b0;
            r_av       <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_GRANT_TO;
            r_state    <= ST_ABORT;
          end
        end
        ST_ADDRESS: begin
          if (w_arb_abort) begin
            r_barq     <= 1'b0;
            r_av       <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_ARB;
            r_state    <= ST_ABORT;
          end else if (bus.target_ready_i) begin
            if (r_len == '0) begin
              r_barq  <= 1'b0;
              r_av    <= 1'b0;
              r_state <= ST_RELEASE;
            end else begin
              r_state <= ST_DATA;
            end
          end else if (w_expired) begin
            r_barq     <= 1'b0;
            r_av       <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TARGET_TO;
            r_state    <= ST_ABORT;
          end
        end
        ST_DATA: begin
          if (w_arb_abort) begin
            r_barq     <= 1'b0;
            r_av       <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_ARB;
            r_state    <= ST_ABORT;
          end else if (bus.data_strobe_i) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_barq  <= 1'b0;
              r_av    <= 1'b0;
              r_state <= ST_RELEASE;
            end
          end else if (w_expired) begin
            r_barq     <= 1'b0;
            r_av       <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TARGET_TO;
            r_state    <= ST_ABORT;
          end
        end
        ST_RELEASE: begin
          if (!bus.bagd_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_expired) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_TARGET_TO;
            r_state    <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_barq  <= 1'b0;
          r_av    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign err_o               = r_err;
  assign err_code_o          = r_err_code;
  assign state_o             = r_state;
  assign cnt_o               = r_cnt;
  assign bus.barq_o          = r_barq;
  assign bus.address_valid_o = r_av;

endmodule
